// File: rtl/reg_file_param.sv
// Parametrised register file: two async read ports, one sync write port,
// one debug port, write-to-read bypass, hardwired zero and sequenced clear.
module reg_file_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              startin,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic              busy,
  output logic              clr_done
);

  localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  typedef enum logic {
    CLEAR,
    RUN
  } state_t;

  state_t            state;
  logic [IW-1:0]     clr_cnt;
  logic [DATA_W-1:0] mem [NUM_REGS];
  logic              wr_ok;
  logic [IW-1:0]     widx;

  // An address is live when it maps to a real, writable entry.
  function automatic logic live(input logic [ADDR_W-1:0] a);
    logic in_rng;
    logic is_zero;
    in_rng  = 32'(a) < 32'(NUM_REGS);
    is_zero = (ZERO_REG != 0) && (a == '0);
    return in_rng && !is_zero;
  endfunction

  assign wr_ok = !busy && wr_en && live(wr_addr);
  assign widx  = wr_addr[IW-1:0];

  function automatic logic [DATA_W-1:0] rd(
    input logic [ADDR_W-1:0] a,
    input logic              byp
  );
    logic [DATA_W-1:0] v;
    v = '0;
    unique case (1'b1)
      busy || !live(a):
        v = '0;
      byp && wr_ok && (wr_addr == a):
        v = wr_data;
      default:
        v = mem[a[IW-1:0]];
    endcase
    return v;
  endfunction

  always_comb begin
    rd_data1 = rd(rd_addr1, BYPASS != 0);
    rd_data2 = rd(rd_addr2, BYPASS != 0);
    dbg_data = rd(dbg_addr, 1'b0);
  end

  always_ff @(posedge clk) begin
    if (startin) begin
      state    <= CLEAR;
      clr_cnt  <= '0;
      busy     <= 1'b1;
      clr_done <= 1'b0;
      mem[0]   <= '0;
    end else begin
      clr_done <= 1'b0;
      unique case (state)
        CLEAR: begin
          mem[clr_cnt] <= '0;
          if (clr_cnt == IW'(NUM_REGS - 1)) begin
            state    <= RUN;
            busy     <= 1'b0;
            clr_done <= 1'b1;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        RUN: begin
          if (wr_ok)
            mem[widx] <= wr_data;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_file_param.sv
// Bench for reg_file_param: a 32-entry and a 24-entry instance share stimulus
// and are compared every cycle against an array-based reference model.
module tb_reg_file_param;

  logic        clk = 1'b0;
  logic        startin;
  logic [4:0]  rd_addr1, rd_addr2, wr_addr, dbg_addr;
  logic        wr_en;
  logic [31:0] wr_data;

  logic [31:0] a_rd1, a_rd2, a_dbg;
  logic [31:0] b_rd1, b_rd2, b_dbg;
  logic        a_busy, a_done, b_busy, b_done;

  always #5 clk = ~clk;

  reg_file_param #(.NUM_REGS(32)) dut_a (
    .clk(clk), .startin(startin),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(a_rd1), .rd_data2(a_rd2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .dbg_addr(dbg_addr), .dbg_data(a_dbg),
    .busy(a_busy), .clr_done(a_done)
  );

  reg_file_param #(.NUM_REGS(24)) dut_b (
    .clk(clk), .startin(startin),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(b_rd1), .rd_data2(b_rd2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .dbg_addr(dbg_addr), .dbg_data(b_dbg),
    .busy(b_busy), .clr_done(b_done)
  );

  int tests = 0;
  int fails = 0;
  bit armed = 0;

  logic [31:0] mm [2][32];
  bit          mbusy [2];
  bit          mdone [2];
  int          left  [2];

  function automatic int nr(int d);
    return (d == 0) ? 32 : 24;
  endfunction

  function automatic logic [31:0] exp_rd(int d, logic [4:0] a, bit byp);
    if (mbusy[d] || a == 0 || int'(a) >= nr(d)) return 32'h0;
    if (byp && wr_en && wr_addr == a) return wr_data;
    return mm[d][a];
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("a_rd1", a_rd1, exp_rd(0, rd_addr1, 1));
    chk("a_rd2", a_rd2, exp_rd(0, rd_addr2, 1));
    chk("a_dbg", a_dbg, exp_rd(0, dbg_addr, 0));
    chk("a_busy", 32'(a_busy), 32'(mbusy[0]));
    chk("a_done", 32'(a_done), 32'(mdone[0]));
    chk("b_rd1", b_rd1, exp_rd(1, rd_addr1, 1));
    chk("b_rd2", b_rd2, exp_rd(1, rd_addr2, 1));
    chk("b_dbg", b_dbg, exp_rd(1, dbg_addr, 0));
    chk("b_busy", 32'(b_busy), 32'(mbusy[1]));
    chk("b_done", 32'(b_done), 32'(mdone[1]));
  endtask

  // Clear is modelled as a countdown that wipes the whole array at once.
  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      mdone[d] = 0;
      if (startin) begin
        mbusy[d] = 1;
        left[d]  = nr(d);
      end else if (mbusy[d]) begin
        left[d]--;
        if (left[d] == 0) begin
          for (int i = 0; i < 32; i++) mm[d][i] = 32'h0;
          mbusy[d] = 0;
          mdone[d] = 1;
        end
      end else if (wr_en && wr_addr != 0 && int'(wr_addr) < nr(d)) begin
        mm[d][wr_addr] = wr_data;
      end
    end
  endtask

  task automatic cyc();
    #1;
    if (armed) check_model();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_clear(output int n, output int p);
    n = 0;
    p = 0;
    while (a_busy && n < 200) begin
      if (a_done) p++;
      cyc();
      n++;
    end
    if (a_done) p++;
  endtask

  int n, p;

  initial begin
    startin = 0; wr_en = 0; wr_addr = 0; wr_data = 0;
    rd_addr1 = 0; rd_addr2 = 0; dbg_addr = 0;
    for (int d = 0; d < 2; d++) begin
      mbusy[d] = 0; mdone[d] = 0; left[d] = 0;
      for (int i = 0; i < 32; i++) mm[d][i] = 32'h0;
    end
    @(posedge clk); #1;

    // 1: single-cycle start, full clear, debug sweep
    startin = 1;
    cyc();
    armed = 1;
    startin = 0;
    wait_clear(n, p);
    chk("t1_busy_cycles", n, 32);
    chk("t1_done_pulses", p, 1);
    cyc();
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i);
      #1;
      chk("t1_dbg_a", a_dbg, 32'h0);
      chk("t1_dbg_b", b_dbg, 32'h0);
    end

    // 2: bypass then stored value
    wr_en = 1; wr_addr = 5; wr_data = 32'hDEADBEEF; rd_addr1 = 5;
    #1;
    chk("t2_bypass_a", a_rd1, 32'hDEADBEEF);
    chk("t2_bypass_b", b_rd1, 32'hDEADBEEF);
    cyc();
    wr_en = 0;
    #1;
    chk("t2_stored", a_rd1, 32'hDEADBEEF);
    cyc();

    // 3: zero register ignores writes
    wr_en = 1; wr_addr = 0; wr_data = 32'h12345678;
    rd_addr1 = 0; rd_addr2 = 0; dbg_addr = 0;
    #1;
    chk("t3_pre_rd1", a_rd1, 32'h0);
    chk("t3_pre_rd2", a_rd2, 32'h0);
    chk("t3_pre_dbg", a_dbg, 32'h0);
    cyc();
    wr_en = 0;
    #1;
    chk("t3_post_rd1", a_rd1, 32'h0);
    chk("t3_post_rd2", a_rd2, 32'h0);
    chk("t3_post_dbg", a_dbg, 32'h0);

    // 4: write during busy is dropped
    wr_en = 1; wr_addr = 7; wr_data = 32'h11110007;
    cyc();
    wr_en = 0; rd_addr1 = 7;
    #1;
    chk("t4_prewrite", a_rd1, 32'h11110007);
    startin = 1;
    cyc();
    startin = 0;
    wr_en = 1; wr_addr = 7; wr_data = 32'hA5A5A5A5;
    cyc();
    wr_en = 0;
    wait_clear(n, p);
    cyc();
    rd_addr1 = 7; dbg_addr = 7;
    #1;
    chk("t4_reg7_rd", a_rd1, 32'h0);
    chk("t4_reg7_dbg", a_dbg, 32'h0);

    // 5: restart mid-clear
    wr_en = 1; wr_addr = 3; wr_data = 32'h33333333;
    cyc();
    wr_addr = 9; wr_data = 32'h99999999;
    cyc();
    wr_en = 0; rd_addr1 = 3; rd_addr2 = 9;
    #1;
    chk("t5_pre3", a_rd1, 32'h33333333);
    chk("t5_pre9", a_rd2, 32'h99999999);
    startin = 1;
    cyc();
    startin = 0;
    repeat (10) cyc();
    startin = 1;
    cyc();
    startin = 0;
    wait_clear(n, p);
    chk("t5_busy_cycles", n, 32);
    chk("t5_done_pulses", p, 1);
    cyc();
    #1;
    chk("t5_reg3", a_rd1, 32'h0);
    chk("t5_reg9", a_rd2, 32'h0);

    // 6: out-of-range write on the 24-entry instance
    wr_en = 1; wr_addr = 30; wr_data = 32'hCAFEF00D;
    rd_addr1 = 30; dbg_addr = 30;
    #1;
    chk("t6_b_bypass", b_rd1, 32'h0);
    chk("t6_a_bypass", a_rd1, 32'hCAFEF00D);
    cyc();
    wr_en = 0;
    #1;
    chk("t6_b_rd", b_rd1, 32'h0);
    chk("t6_b_dbg", b_dbg, 32'h0);
    chk("t6_a_rd", a_rd1, 32'hCAFEF00D);

    // random stream against the model
    for (int k = 0; k < 10000; k++) begin
      startin = ($urandom_range(0, 999) == 0);
      wr_en   = $urandom_range(0, 1) == 1;
      wr_addr = 5'($urandom_range(0, 31));
      wr_data = $urandom;
      rd_addr1 = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31));
      rd_addr2 = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31));
      dbg_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31));
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
